// File: rtl/noc_defs.sv
// noc_defs: shared flit-type, route and FSM encodings for NoC router stages
package noc_defs;
    localparam int ROUTE_W = 3;
    typedef enum logic [1:0] {FT_BODY = 2'b00, FT_HEAD = 2'b01, FT_TAIL = 2'b10, FT_SINGLE = 2'b11} flit_type_t;
    typedef enum logic [ROUTE_W-1:0] {R_N = 3'd0, R_E = 3'd1, R_S = 3'd2, R_W = 3'd3, R_L = 3'd4} route_t;
    typedef enum logic {S_IDLE, S_PKT} state_t;
endpackage

// File: rtl/xy_route_calc.sv
// xy_route_calc: combinational dimension-ordered (X then Y) route decode with range check
//   dest, router_addr : {x,y} coordinates
//   route             : output port code; out-of-mesh destinations eject locally
//   range_err         : dest lies outside the MESH_X x MESH_Y mesh
module xy_route_calc
    import noc_defs::*;
#(
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int MESH_X = 4,
    parameter int MESH_Y = 4
) (
    input  logic [X_W+Y_W-1:0] dest,
    input  logic [X_W+Y_W-1:0] router_addr,
    output route_t             route,
    output logic               range_err
);
    logic [X_W-1:0] dx, rx;
    logic [Y_W-1:0] dy, ry;
    assign {dx, dy} = dest;
    assign {rx, ry} = router_addr;
    assign range_err = 32'(dx) >= MESH_X || 32'(dy) >= MESH_Y;
    assign route = range_err ? R_L :
                   dx > rx   ? R_E :
                   dx < rx   ? R_W :
                   dy > ry   ? R_N :
                   dy < ry   ? R_S : R_L;
endmodule

// File: rtl/xy_route_stage.sv
// xy_route_stage: registered wormhole-aware XY route-compute stage for one router input
//   clk, rst             : clock, asynchronous active-high reset
//   router_addr          : this router's {x,y}
//   in_valid/in_ready    : input handshake, in_flit carries {type, ..., dest}
//   out_valid/out_ready  : output handshake, out_flit = {route, flit}, out_req = one-hot route
//   err                  : one-cycle pulse on protocol or range error
//   pkt_cnt, err_cnt     : saturating packet and error counters
module xy_route_stage
    import noc_defs::*;
#(
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int MESH_X = 4,
    parameter int MESH_Y = 4,
    parameter int FLIT_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [X_W+Y_W-1:0]        router_addr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FLIT_W-1:0]         in_flit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FLIT_W+ROUTE_W-1:0] out_flit,
    output logic [4:0]                out_req,
    output logic                      err,
    output logic [CNT_W-1:0]          pkt_cnt,
    output logic [CNT_W-1:0]          err_cnt
);
    state_t     state, state_nxt;
    route_t     calc_route, route_held, route_sel;
    flit_type_t ftype;
    logic       range_err, xfer, head_like, fwd, err_now, pkt_done;
    assign ftype     = flit_type_t'(in_flit[FLIT_W-1 -: 2]);
    assign head_like = ftype inside {FT_HEAD, FT_SINGLE};
    assign in_ready  = !out_valid || out_ready;
    assign xfer      = in_valid && in_ready;
    assign out_req   = out_valid ? 5'(1) << out_flit[FLIT_W +: ROUTE_W] : '0;
    xy_route_calc #(.X_W(X_W), .Y_W(Y_W), .MESH_X(MESH_X), .MESH_Y(MESH_Y)) u_calc (
        .dest       (in_flit[X_W+Y_W-1:0]),
        .router_addr(router_addr),
        .route      (calc_route),
        .range_err  (range_err)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    // A head/single always restarts routing, even when it interrupts an open packet.
    always_comb
        state_nxt = !xfer     ? state :
                    head_like ? (ftype == FT_HEAD ? S_PKT : S_IDLE) :
                    (state == S_PKT && ftype == FT_TAIL) ? S_IDLE : state;
    // Body/tail arriving with no open packet is consumed but never forwarded.
    always_comb begin
        fwd       = xfer && (head_like || state == S_PKT);
        err_now   = xfer && (head_like ? (state == S_PKT || range_err) : state == S_IDLE);
        pkt_done  = xfer && (ftype == FT_SINGLE || (ftype == FT_TAIL && state == S_PKT));
        route_sel = head_like ? calc_route : route_held;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) route_held <= R_L;
        else if (xfer && ftype == FT_HEAD) route_held <= calc_route;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
            err       <= 1'b0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            if (in_ready) out_valid <= fwd;
            if (fwd) out_flit <= {route_sel, in_flit};
            err <= err_now;
            if (pkt_done && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
            if (err_now && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
endmodule
